// File: rtl/fir_agc_ctrl.sv
// fir_agc_ctrl: windowed clip/peak gain controller driving the FIR wrapper's attenuation shift
module fir_agc_ctrl #(
  parameter int WINDOW_LEN     = 4096,
  parameter int CLIP_HI_THRESH = 16,
  parameter int LOW_PEAK       = 32,
  parameter int HOLD_WINDOWS   = 4,
  parameter int SETTLE_SAMPLES = 128,
  parameter int SHIFT_MIN      = 0,
  parameter int SHIFT_MAX      = 15,
  parameter int SHIFT_INIT     = 4
) (
  input  logic       s00_axis_aclk,
  input  logic       s00_axis_areset,
  input  logic       agc_en,
  input  logic [3:0] manual_shift,
  input  logic       mon_tvalid,
  input  logic       mon_tready,
  input  logic [7:0] mon_tdata,
  output logic [3:0] shift,
  output logic       shift_changed,
  output logic       clip_seen,
  output logic [1:0] agc_state
);
  localparam int CMAX = WINDOW_LEN > SETTLE_SAMPLES ? WINDOW_LEN : SETTLE_SAMPLES;
  localparam int CW = $clog2(CMAX + 1);
  localparam int KW = $clog2(CLIP_HI_THRESH + 1);
  localparam int LW = $clog2(HOLD_WINDOWS + 1);
  localparam logic [CW-1:0] W_LAST = CW'(WINDOW_LEN - 1);
  localparam logic [CW-1:0] S_LAST = CW'(SETTLE_SAMPLES - 1);
  localparam logic [KW-1:0] K_TH = KW'(CLIP_HI_THRESH);
  localparam logic [LW-1:0] L_HOLD = LW'(HOLD_WINDOWS);
  localparam logic [LW-1:0] L_HM1 = LW'(HOLD_WINDOWS - 1);
  localparam logic [7:0] P_LOW = 8'(LOW_PEAK);
  localparam logic [3:0] S_MIN = 4'(SHIFT_MIN);
  localparam logic [3:0] S_MAX = 4'(SHIFT_MAX);
  localparam logic [3:0] S_INIT = 4'(SHIFT_INIT);

  typedef enum logic [1:0] {IDLE, MEASURE, DECIDE, SETTLE} state_t;
  state_t st, st_n;
  logic [CW-1:0] samp_cnt;
  logic [KW-1:0] clip_cnt;
  logic [LW-1:0] low_cnt, low_inc, low_n;
  logic [7:0] peak, dev;
  logic acc, clip, over, quiet, up, dn, chg, clr;

  assign acc = mon_tvalid & mon_tready;
  assign clip = mon_tdata == 8'd0 || mon_tdata == 8'd255;
  assign dev = mon_tdata[7] ? mon_tdata - 8'd128 : 8'd128 - mon_tdata;

  always_ff @(posedge s00_axis_aclk)
    st <= s00_axis_areset ? IDLE : st_n;

  always_comb
    st_n = !agc_en ? IDLE :
           st == IDLE ? MEASURE :
           st == MEASURE ? (acc && samp_cnt == W_LAST ? DECIDE : MEASURE) :
           st == DECIDE ? (chg ? SETTLE : MEASURE) :
           (acc && samp_cnt == S_LAST ? MEASURE : SETTLE);

  always_comb begin
    over = clip_cnt >= K_TH;
    quiet = peak < P_LOW;
    low_inc = low_cnt >= L_HM1 ? L_HOLD : low_cnt + LW'(1);
    up = over && shift < S_MAX;
    dn = !over && quiet && low_inc == L_HOLD && shift > S_MIN;
    chg = agc_en && st == DECIDE && (up || dn);
    low_n = !agc_en ? '0 : st != DECIDE ? low_cnt : (over || !quiet || dn) ? '0 : low_inc;
    clr = st_n == IDLE || (st_n != st && st_n != DECIDE);
    agc_state = st;
  end

  // Window stats stay intact on the MEASURE->DECIDE edge so DECIDE can judge them
  always_ff @(posedge s00_axis_aclk)
    if (s00_axis_areset) begin
      shift <= S_INIT;
      shift_changed <= 1'b0;
      clip_seen <= 1'b0;
      low_cnt <= '0;
      samp_cnt <= '0;
      clip_cnt <= '0;
      peak <= '0;
    end else begin
      shift <= st == IDLE ? manual_shift : chg ? (up ? shift + 4'd1 : shift - 4'd1) : shift;
      shift_changed <= chg;
      clip_seen <= st_n != st ? 1'b0 : clip_seen | (st == MEASURE && acc && clip);
      low_cnt <= low_n;
      if (clr) begin
        samp_cnt <= '0;
        clip_cnt <= '0;
        peak <= '0;
      end else if (acc) begin
        samp_cnt <= samp_cnt + CW'(1);
        if (st == MEASURE) begin
          clip_cnt <= clip && clip_cnt != K_TH ? clip_cnt + KW'(1) : clip_cnt;
          peak <= dev > peak ? dev : peak;
        end
      end
    end
endmodule

// File: tb/tb_fir_agc_ctrl.sv
// tb_fir_agc_ctrl: vector table, directed corner sequences and random traffic against a window-level model
module tb_fir_agc_ctrl;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, valid = 1'b0, ready = 1'b0;
  logic [3:0] man = 4'd0;
  logic [7:0] data = 8'd128;
  logic [3:0] shift;
  logic chg, seen;
  logic [1:0] st;

  fir_agc_ctrl #(.WINDOW_LEN(16), .CLIP_HI_THRESH(4), .LOW_PEAK(32), .HOLD_WINDOWS(2),
                 .SETTLE_SAMPLES(8), .SHIFT_MIN(0), .SHIFT_MAX(15), .SHIFT_INIT(4)) dut (
    .s00_axis_aclk(clk), .s00_axis_areset(rst), .agc_en(en), .manual_shift(man),
    .mon_tvalid(valid), .mon_tready(ready), .mon_tdata(data),
    .shift(shift), .shift_changed(chg), .clip_seen(seen), .agc_state(st));

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;
  int m_mode = 0, m_shift = 4, m_low = 0, m_settle = 0;
  bit m_chg = 1'b0, m_seen = 1'b0;
  int win[$];

  // Decision works on the whole stored window rather than running counters
  task automatic model_decide();
    int clips = 0, pk = 0;
    foreach (win[i]) begin
      int d = win[i] >= 128 ? win[i] - 128 : 128 - win[i];
      if (win[i] == 0 || win[i] == 255) clips++;
      if (d > pk) pk = d;
    end
    if (clips >= 4) begin
      m_low = 0;
      if (m_shift < 15) begin m_shift++; m_chg = 1'b1; end
    end else if (pk < 32) begin
      m_low = m_low + 1 > 2 ? 2 : m_low + 1;
      if (m_low == 2 && m_shift > 0) begin m_shift--; m_low = 0; m_chg = 1'b1; end
    end else m_low = 0;
    m_mode = m_chg ? 3 : 1;
    m_settle = 0;
    m_seen = 1'b0;
    win.delete();
  endtask

  task automatic model_edge();
    m_chg = 1'b0;
    if (rst) begin
      m_mode = 0; m_shift = 4; m_low = 0; m_seen = 1'b0; win.delete();
    end else if (!en) begin
      if (m_mode == 0) m_shift = int'(man);
      m_mode = 0; m_low = 0; m_seen = 1'b0; win.delete();
    end else if (m_mode == 0) begin
      m_shift = int'(man); m_mode = 1; m_seen = 1'b0; win.delete();
    end else if (m_mode == 1) begin
      if (valid && ready) begin
        win.push_back(int'(data));
        if (data == 8'd0 || data == 8'd255) m_seen = 1'b1;
        if (win.size() == 16) begin m_mode = 2; m_seen = 1'b0; end
      end
    end else if (m_mode == 2) model_decide();
    else if (valid && ready) begin
      m_settle++;
      if (m_settle == 8) begin m_mode = 1; win.delete(); end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    vectors++;
    if (shift !== 4'(m_shift) || st !== 2'(m_mode) || chg !== m_chg || seen !== m_seen) begin
      miscompares++;
      $display("FAIL model @%0t: got shift=%0d state=%0d chg=%0b seen=%0b, expected shift=%0d state=%0d chg=%0b seen=%0b",
               $time, shift, st, chg, seen, m_shift, m_mode, m_chg, m_seen);
    end
  endtask

  task automatic chk(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic put(input logic v, input logic r, input logic [7:0] d);
    valid = v; ready = r; data = d;
    tick();
  endtask

  task automatic samp(input logic [7:0] d);
    put(1'b1, 1'b1, d);
  endtask

  task automatic win16(input logic [7:0] d);
    repeat (16) samp(d);
    put(1'b0, 1'b0, 8'd128);
  endtask

  typedef struct {
    bit rst, en; int man; bit v, r; int d;
    int e_shift, e_st; bit e_chg, e_seen;
  } vec_t;
  vec_t tbl[10];

  initial begin
    tbl[0] = '{1'b1, 1'b0, 0, 1'b0, 1'b0, 128, 4, 0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 9, 1'b0, 1'b0, 128, 9, 0, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 3, 1'b1, 1'b1, 0,   3, 0, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 4, 1'b0, 1'b0, 128, 4, 1, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 4, 1'b1, 1'b1, 0,   4, 1, 1'b0, 1'b1};
    tbl[5] = '{1'b0, 1'b1, 4, 1'b1, 1'b0, 128, 4, 1, 1'b0, 1'b1};
    tbl[6] = '{1'b0, 1'b1, 9, 1'b1, 1'b1, 128, 4, 1, 1'b0, 1'b1};
    tbl[7] = '{1'b0, 1'b0, 9, 1'b1, 1'b1, 255, 4, 0, 1'b0, 1'b0};
    tbl[8] = '{1'b0, 1'b0, 9, 1'b0, 1'b0, 128, 9, 0, 1'b0, 1'b0};
    tbl[9] = '{1'b1, 1'b1, 9, 1'b0, 1'b0, 128, 4, 0, 1'b0, 1'b0};
    foreach (tbl[i]) begin
      rst = tbl[i].rst; en = tbl[i].en; man = 4'(tbl[i].man);
      put(tbl[i].v, tbl[i].r, 8'(tbl[i].d));
      chk($sformatf("tbl%0d_shift", i), int'(shift), tbl[i].e_shift);
      chk($sformatf("tbl%0d_state", i), int'(st), tbl[i].e_st);
      chk($sformatf("tbl%0d_chg", i), int'(chg), int'(tbl[i].e_chg));
      chk($sformatf("tbl%0d_seen", i), int'(seen), int'(tbl[i].e_seen));
    end

    // Heavy clipping steps shift up, then the settle period runs
    rst = 1'b0; en = 1'b1; man = 4'd4;
    put(1'b0, 1'b0, 8'd128);
    repeat (5) samp(8'd255);
    repeat (10) samp(8'd128);
    chk("clip_seen_sticky", int'(seen), 1);
    samp(8'd128);
    chk("clip_decide", int'(st), 2);
    put(1'b0, 1'b0, 8'd128);
    chk("clip_shift_up", int'(shift), 5);
    chk("clip_pulse", int'(chg), 1);
    chk("clip_to_settle", int'(st), 3);
    put(1'b0, 1'b0, 8'd128);
    chk("clip_pulse_end", int'(chg), 0);
    repeat (7) samp(8'd128);
    chk("settle_hold", int'(st), 3);
    samp(8'd128);
    chk("settle_done", int'(st), 1);

    // Quiet windows step down only after two in a row
    rst = 1'b1; put(1'b0, 1'b0, 8'd128);
    rst = 1'b0; put(1'b0, 1'b0, 8'd128);
    win16(8'd140);
    chk("quiet1_shift", int'(shift), 4);
    win16(8'd200);
    chk("loud_shift", int'(shift), 4);
    win16(8'd140);
    chk("quiet2_shift", int'(shift), 4);
    win16(8'd140);
    chk("quiet3_shift_down", int'(shift), 3);
    chk("quiet3_state", int'(st), 3);

    // At SHIFT_MAX heavy clipping changes nothing
    rst = 1'b1; put(1'b0, 1'b0, 8'd128);
    rst = 1'b0; man = 4'd15; put(1'b0, 1'b0, 8'd128);
    repeat (16) samp(8'd255);
    chk("max_decide", int'(st), 2);
    put(1'b0, 1'b0, 8'd128);
    chk("max_shift", int'(shift), 15);
    chk("max_no_pulse", int'(chg), 0);
    chk("max_to_measure", int'(st), 1);

    // Stalled handshakes are not samples
    repeat (50) put(1'b1, 1'b0, 8'd0);
    repeat (5) put(1'b0, 1'b1, 8'd255);
    chk("stall_no_clip", int'(seen), 0);
    repeat (15) samp(8'd128);
    chk("stall_measure", int'(st), 1);
    samp(8'd128);
    chk("stall_decide", int'(st), 2);
    put(1'b0, 1'b0, 8'd128);
    chk("stall_single_decide", int'(st), 1);

    // Dropping agc_en discards the partial window
    repeat (10) samp(8'd128);
    en = 1'b0; put(1'b0, 1'b0, 8'd128);
    chk("drop_idle", int'(st), 0);
    man = 4'd4; en = 1'b1; put(1'b0, 1'b0, 8'd128);
    chk("reenable_shift", int'(shift), 4);
    repeat (15) samp(8'd128);
    chk("reenable_measure", int'(st), 1);
    samp(8'd128);
    chk("reenable_decide", int'(st), 2);
    put(1'b0, 1'b0, 8'd128);

    // Reset while settling
    win16(8'd255);
    repeat (3) samp(8'd128);
    chk("pre_reset_settle", int'(st), 3);
    rst = 1'b1; put(1'b0, 1'b0, 8'd128);
    chk("rst_shift", int'(shift), 4);
    chk("rst_state", int'(st), 0);
    chk("rst_flags", int'({chg, seen}), 0);
    rst = 1'b0;

    begin
      int regime = 0, bd = 0;
      for (int c = 0; c < 4000; c++) begin
        int x;
        if (c % 64 == 0) begin
          regime = int'($urandom_range(0, 4));
          bd = $urandom_range(0, 1) != 0 ? 31 : 32;
        end
        rst = $urandom_range(0, 999) == 0;
        en = $urandom_range(0, 299) != 0;
        man = 4'($urandom);
        case (regime)
          0: x = 108 + int'($urandom_range(0, 40));
          1: x = $urandom_range(0, 2) == 0 ? 255 : int'($urandom_range(0, 255));
          2: x = 78 + int'($urandom_range(0, 100));
          3: x = $urandom_range(0, 1) != 0 ? 128 + bd : 128 - bd;
          default: x = $urandom_range(0, 4) == 0 ? 0 : 128;
        endcase
        put($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 8'(x));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
